// File: rtl/cov_mon_pkg.sv
// Shared state encoding, reason codes and saturating arithmetic for the
// coverage stall watchdog.
package cov_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIRE,
    COOLDOWN
  } mon_state_e;

  localparam logic [1:0] R_STALL = 2'd1;
  localparam logic [1:0] R_WDOG  = 2'd2;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock_i,
  input  logic         reset_n_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !(&count_q)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(negedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cov_stall_watchdog.sv
// Multi-channel coverage stall / round watchdog raising a level interrupt
// toward the DUT. All state advances on the falling edge of clock.
//
// state    | meaning
// IDLE     | disarmed, counters held at zero
// RUN      | counting stall and round cycles, checking for a fire
// FIRE     | interrupt asserted, counters frozen, waiting for irq_ack
// COOLDOWN | interrupt dropped, counters cleared, coverage re-tracked
module cov_stall_watchdog
  import cov_mon_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int COV_WIDTH      = 30,
  parameter int CNT_W          = 32,
  parameter int BASE_WAIT      = 1000,
  parameter int SCALE_SHIFT    = 19,
  parameter int WATCHDOG_LIMIT = 50000,
  parameter int COOL_CYCLES    = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [NUM_CH*COV_WIDTH-1:0] cov,
  input  logic [63:0]                 tohost,
  input  logic                        irq_ack,
  output logic                        interrupt,
  output logic [1:0]                  irq_reason,
  output logic [CNT_W-1:0]            stall_count,
  output logic [15:0]                 fire_count
);

  localparam int LIM_W  = CNT_W + COV_WIDTH;
  localparam int COOL_W = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  WDOG_LIM  = CNT_W'(WATCHDOG_LIMIT);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOL_CYCLES - 1);

  mon_state_e                  state_q, state_d;
  logic [NUM_CH*COV_WIDTH-1:0] prev_cov_q, prev_cov_d;
  logic [COOL_W-1:0]           cool_q, cool_d;
  logic                        irq_q, irq_d;
  logic [1:0]                  reason_q, reason_d;
  logic [15:0]                 fires_q, fires_d;

  logic [CNT_W-1:0] stall_cnt, wdog_cnt;
  logic             stall_clr, stall_inc, wdog_clr, wdog_inc;
  logic [1:0]       fire_reason;

  logic [COV_WIDTH-1:0] cov_ch0;
  logic [LIM_W-1:0]     limit_wide;
  logic [CNT_W-1:0]     stall_limit;
  logic                 cov_moved, stall_hit, wdog_hit;
  logic                 tohost_unused;

  // Window grows with channel-0 coverage; widened so the product cannot wrap.
  assign cov_ch0     = cov[COV_WIDTH-1:0];
  assign limit_wide  = LIM_W'(BASE_WAIT) * (LIM_W'(cov_ch0 >> SCALE_SHIFT) + LIM_W'(1));
  assign stall_limit = (|limit_wide[LIM_W-1:CNT_W]) ? '1 : limit_wide[CNT_W-1:0];

  assign cov_moved     = (cov != prev_cov_q);
  assign stall_hit     = (stall_cnt >= stall_limit);
  assign wdog_hit      = (wdog_cnt >= WDOG_LIM);
  assign tohost_unused = ^tohost[63:1];

  always_comb begin
    state_d     = state_q;
    prev_cov_d  = prev_cov_q;
    cool_d      = cool_q;
    irq_d       = irq_q;
    reason_d    = reason_q;
    fires_d     = fires_q;
    stall_clr   = 1'b0;
    stall_inc   = 1'b0;
    wdog_clr    = 1'b0;
    wdog_inc    = 1'b0;
    fire_reason = 2'b00;

    if (!enable) begin
      state_d   = IDLE;
      irq_d     = 1'b0;
      stall_clr = 1'b1;
      wdog_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          stall_clr  = 1'b1;
          wdog_clr   = 1'b1;
          prev_cov_d = cov;
          state_d    = RUN;
        end
        RUN: begin
          if (tohost[0]) begin
            stall_clr = 1'b1;
            wdog_clr  = 1'b1;
          end else if (cov_moved) begin
            prev_cov_d = cov;
            // Moving coverage cancels a stall, but an overlong round still trips.
            if (wdog_hit) begin
              fire_reason = R_WDOG;
            end else begin
              stall_clr = 1'b1;
              wdog_inc  = 1'b1;
            end
          end else begin
            fire_reason = (stall_hit ? R_STALL : 2'b00) | (wdog_hit ? R_WDOG : 2'b00);
            if (fire_reason == 2'b00) begin
              stall_inc = 1'b1;
              wdog_inc  = 1'b1;
            end
          end
          if (fire_reason != 2'b00) begin
            state_d  = FIRE;
            irq_d    = 1'b1;
            reason_d = fire_reason;
            fires_d  = sat_add16(fires_q, 16'd1);
          end
        end
        FIRE: begin
          if (irq_ack) begin
            state_d   = COOLDOWN;
            irq_d     = 1'b0;
            stall_clr = 1'b1;
            wdog_clr  = 1'b1;
            cool_d    = COOL_LOAD;
          end
        end
        COOLDOWN: begin
          stall_clr  = 1'b1;
          wdog_clr   = 1'b1;
          prev_cov_d = cov;
          if (cool_q == '0) begin
            state_d = RUN;
          end else begin
            cool_d = cool_q - COOL_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      prev_cov_q <= '0;
      cool_q     <= '0;
      irq_q      <= 1'b0;
      reason_q   <= 2'b00;
      fires_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      prev_cov_q <= prev_cov_d;
      cool_q     <= cool_d;
      irq_q      <= irq_d;
      reason_q   <= reason_d;
      fires_q    <= fires_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .clr_i     (stall_clr),
    .inc_i     (stall_inc),
    .count_o   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wdog_cnt (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .clr_i     (wdog_clr),
    .inc_i     (wdog_inc),
    .count_o   (wdog_cnt)
  );

  assign interrupt   = irq_q;
  assign irq_reason  = reason_q;
  assign stall_count = stall_cnt;
  assign fire_count  = fires_q;

endmodule
